// File: rtl/sodor5_verif_pkg.sv
// Shared definitions for the sodor5_verif RV32I OP-IMM reference model.
// Optional build macro: SODOR5_SHIFT_CHECK_EN (rejects shifts with non-canonical imm[11:5]).
package sodor5_verif_pkg;

    localparam logic [6:0] OPCODE_OP_IMM     = 7'b0010011;
    localparam int         NUM_REGS_DEFAULT  = 32;
    localparam int         WORD_SIZE_DEFAULT = 32;

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SLL  = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SRX  = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } funct3_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        funct3_e     funct3;
        logic [4:0]  rs1;
        logic [31:0] imm;
    } decoded_instr_t;

    function automatic decoded_instr_t decode(input logic [31:0] instr);
        decoded_instr_t d;
        d.opcode = instr[6:0];
        d.rd     = instr[11:7];
        d.funct3 = funct3_e'(instr[14:12]);
        d.rs1    = instr[19:15];
        d.imm    = {{20{instr[31]}}, instr[31:20]};
        return d;
    endfunction

endpackage

// File: rtl/sodor5_verif_isa_model.sv
// Register file plus single-cycle OP-IMM ALU; write-back happens on the edge that samples instr.
// Optional build macro: SODOR5_SHIFT_CHECK_EN.
module sodor5_isa_model
    import sodor5_verif_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEFAULT,
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    output logic                 legal,
    output logic [4:0]           rd,
    output logic [WORD_SIZE-1:0] result
);

    logic [WORD_SIZE-1:0] regfile [0:NUM_REGS-1];

    decoded_instr_t       dec;
    logic [WORD_SIZE-1:0] rs1_val;
    logic [WORD_SIZE-1:0] imm_w;
    logic [4:0]           shamt;

    assign dec   = decode(instr);
    assign imm_w = dec.imm;
    assign shamt = dec.imm[4:0];
    assign rd    = dec.rd;

    // x0 is hardwired to zero on read; its storage may hold anything.
    assign rs1_val = (dec.rs1 == 5'd0) ? '0 : regfile[dec.rs1];

    always_comb begin
        result = '0;
        legal  = (dec.opcode == OPCODE_OP_IMM);
        case (dec.funct3)
            F3_ADD:  result = rs1_val + imm_w;
            F3_SLT:  result = {{(WORD_SIZE-1){1'b0}}, ($signed(rs1_val) < $signed(imm_w))};
            F3_SLTU: result = {{(WORD_SIZE-1){1'b0}}, (rs1_val < imm_w)};
            F3_XOR:  result = rs1_val ^ imm_w;
            F3_OR:   result = rs1_val | imm_w;
            F3_AND:  result = rs1_val & imm_w;
            F3_SLL: begin
                result = rs1_val << shamt;
`ifdef SODOR5_SHIFT_CHECK_EN
                if (dec.imm[11:5] != 7'b0000000)
                    legal = 1'b0;
`endif
            end
            F3_SRX: begin
                // imm[10] picks arithmetic vs logical right shift.
                if (dec.imm[10])
                    result = $unsigned($signed(rs1_val) >>> shamt);
                else
                    result = rs1_val >> shamt;
`ifdef SODOR5_SHIFT_CHECK_EN
                if ((dec.imm[11:5] != 7'b0000000) && (dec.imm[11:5] != 7'b0100000))
                    legal = 1'b0;
`endif
            end
            default: result = '0;
        endcase
    end

    // Register contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && legal && (dec.rd != 5'd0))
            regfile[dec.rd] <= result;
    end

endmodule

// File: rtl/sodor5_verif.sv
// Top of the RV32I OP-IMM reference model: registered commit outputs and retirement counter.
// Optional build macro: SODOR5_SHIFT_CHECK_EN (handled inside sodor5_isa_model).
module sodor5_verif
    import sodor5_verif_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEFAULT,
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [WORD_SIZE-1:0] commit_wdata,
    output logic                 illegal,
    output logic [31:0]          retire_count
);

    logic                 legal;
    logic [4:0]           exec_rd;
    logic [WORD_SIZE-1:0] exec_result;

    logic                 commit_valid_reg;
    logic [4:0]           commit_rd_reg;
    logic [WORD_SIZE-1:0] commit_wdata_reg;
    logic                 illegal_reg;
    logic [31:0]          retire_count_reg;

    sodor5_isa_model #(
        .NUM_REGS  (NUM_REGS),
        .WORD_SIZE (WORD_SIZE)
    ) s5m (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .legal  (legal),
        .rd     (exec_rd),
        .result (exec_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid_reg <= 1'b0;
            commit_rd_reg    <= '0;
            commit_wdata_reg <= '0;
            illegal_reg      <= 1'b0;
            retire_count_reg <= '0;
        end else begin
            commit_valid_reg <= legal;
            illegal_reg      <= !legal;
            // Rejected instructions report a clean zero destination/result.
            commit_rd_reg    <= legal ? exec_rd : '0;
            commit_wdata_reg <= legal ? exec_result : '0;
            if (legal)
                retire_count_reg <= retire_count_reg + 32'd1;
        end
    end

    assign commit_valid = commit_valid_reg;
    assign commit_rd    = commit_rd_reg;
    assign commit_wdata = commit_wdata_reg;
    assign illegal      = illegal_reg;
    assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_sodor5_verif.sv
// Self-checking bench for sodor5_verif: directed cases plus randomized OP-IMM stream vs a reference model.
module tb_sodor5_verif;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;
    logic        illegal;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_regs [0:31];
    logic [31:0] ref_retire;

    always #5 clk = ~clk;

    sodor5_verif dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_wdata (commit_wdata),
        .illegal      (illegal),
        .retire_count (retire_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Reference semantics from the ISA rules: returns {legal, result}.
    function automatic logic [32:0] model_exec(input logic [31:0] ins);
        logic [31:0] src, imm, res;
        logic [4:0]  sh;
        logic        ok;
        src = (ins[19:15] == 5'd0) ? 32'h0 : ref_regs[ins[19:15]];
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        ok  = (ins[6:0] == 7'b0010011);
        res = 32'h0;
        case (ins[14:12])
            3'd0: res = src + imm;
            3'd2: res = ((src ^ 32'h80000000) < (imm ^ 32'h80000000)) ? 32'd1 : 32'd0;
            3'd3: res = (src < imm) ? 32'd1 : 32'd0;
            3'd4: res = src ^ imm;
            3'd6: res = src | imm;
            3'd7: res = src & imm;
            3'd1: begin
                res = src << sh;
`ifdef SODOR5_SHIFT_CHECK_EN
                if (ins[31:25] != 7'h00) ok = 1'b0;
`endif
            end
            default: begin
                if (ins[30])
                    res = (src >> sh) | (src[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
                else
                    res = src >> sh;
`ifdef SODOR5_SHIFT_CHECK_EN
                if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) ok = 1'b0;
`endif
            end
        endcase
        return {ok, res};
    endfunction

    task automatic set_reg(input int idx, input logic [31:0] val);
        dut.s5m.regfile[idx] = val;
        ref_regs[idx] = val;
    endtask

    task automatic step(input logic [31:0] ins, input logic rst);
        logic [32:0] m;
        logic [4:0]  rd;
        @(negedge clk);
        instr = ins;
        reset = rst;
        m  = model_exec(ins);
        rd = ins[11:7];
        @(posedge clk);
        #1;
        if (rst) begin
            ref_retire = 32'h0;
            check("rst_valid", {31'h0, commit_valid}, 32'h0);
            check("rst_illegal", {31'h0, illegal}, 32'h0);
            check("rst_rd", {27'h0, commit_rd}, 32'h0);
            check("rst_wdata", commit_wdata, 32'h0);
        end else if (m[32]) begin
            if (rd != 5'd0) ref_regs[rd] = m[31:0];
            ref_retire = ref_retire + 32'd1;
            check("valid", {31'h0, commit_valid}, 32'h1);
            check("illegal", {31'h0, illegal}, 32'h0);
            check("rd", {27'h0, commit_rd}, {27'h0, rd});
            check("wdata", commit_wdata, m[31:0]);
            if (rd != 5'd0) check("regfile_wr", dut.s5m.regfile[rd], m[31:0]);
        end else begin
            check("rej_valid", {31'h0, commit_valid}, 32'h0);
            check("rej_illegal", {31'h0, illegal}, 32'h1);
        end
        check("retire_count", retire_count, ref_retire);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] saved;
        reset = 1'b1;
        instr = 32'h00000013;
        ref_retire = 32'h0;
        for (int i = 0; i < 32; i++) set_reg(i, $urandom);

        // Reset state
        step(32'h00000013, 1'b1);

        // Reset discards an in-flight ADDI x1,x0,1; NOP afterwards retires
        saved = ref_regs[1];
        step(32'h00100093, 1'b1);
        check("rst_no_write", dut.s5m.regfile[1], saved);
        step(32'h00000013, 1'b0);
        check("nop_valid", {31'h0, commit_valid}, 32'h1);
        check("nop_retire", retire_count, 32'd1);

        // ADDI x2,x1,-1
        set_reg(1, 32'h5);
        step(enc(12'hFFF, 5'd1, 3'd0, 5'd2), 1'b0);
        check("addi_wdata", commit_wdata, 32'h4);
        check("addi_x2", dut.s5m.regfile[2], 32'h4);

        // SLTI / SLTIU
        set_reg(1, 32'h80000000);
        step(enc(12'h000, 5'd1, 3'd2, 5'd3), 1'b0);
        check("slti_neg", commit_wdata, 32'h1);
        set_reg(1, 32'h5);
        step(enc(12'hFFF, 5'd1, 3'd3, 5'd3), 1'b0);
        check("sltiu_m1", commit_wdata, 32'h1);
        step(enc(12'h000, 5'd1, 3'd2, 5'd3), 1'b0);
        check("slti_pos", commit_wdata, 32'h0);

        // Shifts
        set_reg(1, 32'h80000000);
        step(enc(12'h404, 5'd1, 3'd5, 5'd4), 1'b0);
        check("srai", commit_wdata, 32'hF8000000);
        step(enc(12'h004, 5'd1, 3'd5, 5'd4), 1'b0);
        check("srli", commit_wdata, 32'h08000000);
        step(enc(12'h001, 5'd1, 3'd1, 5'd4), 1'b0);
        check("slli", commit_wdata, 32'h00000000);

        // x0 behaviour and back-to-back dependency
        set_reg(0, 32'hDEADBEEF);
        step(enc(12'h007, 5'd0, 3'd0, 5'd5), 1'b0);
        check("x0_read", commit_wdata, 32'h7);
        step(enc(12'h001, 5'd5, 3'd0, 5'd0), 1'b0);
        check("x0_rd", {27'h0, commit_rd}, 32'h0);
        check("x0_wdata", commit_wdata, 32'h8);
        check("x5_kept", dut.s5m.regfile[5], 32'h7);

        // Non-canonical SLLI immediate
        set_reg(1, 32'h1);
        saved = ref_regs[6];
        step(enc(12'h021, 5'd1, 3'd1, 5'd6), 1'b0);
`ifdef SODOR5_SHIFT_CHECK_EN
        check("slli_chk_illegal", {31'h0, illegal}, 32'h1);
        check("slli_chk_nowrite", dut.s5m.regfile[6], saved);
`else
        check("slli_nochk", commit_wdata, 32'h2);
`endif

        // Illegal opcode
        saved = ref_regs[7];
        step(32'h00108383, 1'b0);
        check("bad_op_nowrite", dut.s5m.regfile[7], saved);

        // Retire counter wrap
        dut.retire_count_reg = 32'hFFFFFFFF;
        ref_retire = 32'hFFFFFFFF;
        step(32'h00000013, 1'b0);
        check("retire_wrap", retire_count, 32'h0);

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0)
                ins[6:0] = 7'b0010011;
            else if (ins[6:0] == 7'b0010011)
                ins[6:0] = 7'b0110011;
            if ($urandom_range(0, 3) == 0)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            step(ins, ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sodor5_verif.md
SODOR5_VERIF -- requirements
Module: sodor5_verif

Interface
REQ-001 Parameter NUM_REGS, 32, number of architectural integer registers.
REQ-002 Parameter WORD_SIZE, 32, register and datapath width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  32  RV32I instruction word; one instruction is consumed every cycle.
REQ-006 commit_valid  output  1  previous instruction retired legally.
REQ-007 commit_rd  output  5  destination register index of the retired instruction.
REQ-008 commit_wdata  output  WORD_SIZE  result value of the retired instruction.
REQ-009 illegal  output  1  previous instruction was rejected.
REQ-010 retire_count  output  32  count of legally retired instructions.

Function
REQ-011 The block SHALL act as an in-order, single-cycle ISA reference model for RV32I OP-IMM instructions (opcode 0010011).
- Supported: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
REQ-012 Field decode SHALL be: rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], imm=instr[31:20].
- imm is sign-extended to 32 bits.
REQ-013 Operation per funct3:
- 0 add
- 2 signed less-than, result 1 or 0
- 3 unsigned less-than against the sign-extended imm
- 4 xor; 6 or; 7 and
- 1 shift left logical by imm[4:0]
- 5 shift right by imm[4:0]: arithmetic if imm[10]=1, else logical
REQ-014 All arithmetic SHALL be modulo 2^32.
REQ-015 Reading register 0 SHALL return 0 regardless of its stored content.
REQ-016 Write-back:
- Result SHALL be written to regfile[rd] at the rising edge that samples instr.
- No write SHALL occur when rd=0.
REQ-017 commit_valid, commit_rd, commit_wdata and illegal SHALL be registered.
- They reflect the instruction sampled at the previous edge (latency 1).
REQ-018 Back-to-back dependency: an instruction SHALL read the value written by the immediately preceding instruction, with no stall or bubble.
REQ-019 An instruction with rd=0 SHALL still retire.
- commit_valid=1, commit_rd=0, commit_wdata=computed value.
REQ-020 A non-OP-IMM opcode SHALL be rejected:
- no write; illegal=1, commit_valid=0.
- retire_count unchanged.
REQ-021 retire_count SHALL increment by 1 per legal retirement and wrap from 0xFFFFFFFF to 0.

Reset
REQ-022 While reset=1 at an edge, the block SHALL perform no regfile write.
- All outputs SHALL read 0 after that edge, including retire_count.
REQ-023 The regfile SHALL NOT be cleared by reset.
- Contents persist and are loadable by hierarchical initialisation through instance s5m, array regfile[0..31].
REQ-024 Reset asserted mid-stream SHALL discard the instruction sampled in that cycle.

Configuration
REQ-025 Macro SODOR5_SHIFT_CHECK_EN.
- When defined: funct3=1 with imm[11:5]≠0, or funct3=5 with imm[11:5] not in {0000000, 0100000}, SHALL be rejected as in REQ-020.
- When undefined: those imm bits SHALL be ignored, except imm[10] as selector for funct3=5.

Structure
REQ-026 A shared package SHALL hold:
- the OP-IMM opcode constant;
- the funct3 encodings;
- NUM_REGS and WORD_SIZE defaults;
- the decoded-instruction struct typedef.
REQ-027 The design SHALL contain one sub-module, sodor5_isa_model, instantiated as s5m.
- s5m owns regfile and the ALU.
- The top owns output registers and retire_count.

Verification
REQ-028 x1=0x00000005; ADDI x2,x1,-1 (imm 0xFFF) -> next cycle commit_valid=1, commit_rd=2, commit_wdata=0x00000004; regfile[2]=4.
REQ-029 x1=0x80000000:
- SLTI x3,x1,0 -> wdata 1.
- then x1=5; SLTIU x3,x1,-1 -> wdata 1.
- then SLTI x3,x1,0 with x1=5 -> wdata 0.
REQ-030 x1=0x80000000:
- SRAI x4,x1,4 (imm 0x404) -> 0xF8000000.
- SRLI x4,x1,4 (imm 0x004) -> 0x08000000.
- SLLI x4,x1,1 -> 0x00000000.
REQ-031 regfile[0]=0xDEADBEEF; ADDI x5,x0,7 then ADDI x0,x5,1:
- first -> wdata 7;
- second -> commit_rd=0, wdata 8, regfile[5] stays 7;
- x0 reads 0.
REQ-032 reset=1 with instr 0x00100093 -> outputs 0, regfile[1] unchanged; after release, NOP 0x00000013 -> commit_valid=1, retire_count=1.
REQ-033 SLLI imm 0x021 with x1=1:
- with SODOR5_SHIFT_CHECK_EN -> illegal=1, no write;
- without -> commit_wdata=0x00000002.
